// File: rtl/argmax_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_collector_if
// Purpose  : Score stream handshake and argmax result bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface argmax_collector_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic                     start;
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic        [IDX_W-1:0]  class_idx;
    logic signed [DATA_W-1:0] max_score;
    logic                     valid_all;
    logic                     busy;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, class_idx, max_score, valid_all, busy
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, class_idx, max_score, valid_all, busy
    );
endinterface
`default_nettype wire

// File: rtl/argmax_collector.sv
`default_nettype none
// ============================================================================
// Module   : argmax_collector
// Purpose  : Streams NUM_CLASSES signed scores and reports the argmax.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_collector #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = 4
) (
    input wire logic          clk,
    input wire logic          rst_n,
    argmax_collector_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(NUM_CLASSES - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic        [IDX_W-1:0]  r_cnt;
    logic                     r_have;
    logic signed [DATA_W-1:0] r_run_max;
    logic        [IDX_W-1:0]  r_run_idx;
    logic        [IDX_W-1:0]  r_class_idx;
    logic signed [DATA_W-1:0] r_max_score;
    logic                     r_valid_all;

    logic                     w_collect;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_take;
    logic signed [DATA_W-1:0] w_new_max;
    logic        [IDX_W-1:0]  w_new_idx;

    assign w_collect = (r_state == S_COLLECT);
    assign w_accept  = w_collect && bus.in_valid;
    assign w_last    = (r_cnt == C_LAST);
    // Strict greater-than keeps the earliest index on ties.
    assign w_take    = !r_have || (bus.in_data > r_run_max);
    assign w_new_max = w_take ? bus.in_data : r_run_max;
    assign w_new_idx = w_take ? r_cnt : r_run_idx;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.start)           w_state_nxt = S_COLLECT;
            S_COLLECT: if (w_accept && w_last)  w_state_nxt = S_DONE;
            S_DONE:    if (bus.start)           w_state_nxt = S_COLLECT;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_have      <= 1'b0;
            r_run_max   <= '0;
            r_run_idx   <= '0;
            r_class_idx <= '0;
            r_max_score <= '0;
            r_valid_all <= 1'b0;
        end else begin
            if (!w_collect && bus.start) begin
                r_cnt       <= '0;
                r_have      <= 1'b0;
                r_valid_all <= 1'b0;
            end
            if (w_accept) begin
                r_run_max <= w_new_max;
                r_run_idx <= w_new_idx;
                r_have    <= 1'b1;
                if (w_last) begin
                    // Result includes the final sample itself.
                    r_class_idx <= w_new_idx;
                    r_max_score <= w_new_max;
                    r_valid_all <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_collect;
    assign bus.busy      = w_collect;
    assign bus.class_idx = r_class_idx;
    assign bus.max_score = r_max_score;
    assign bus.valid_all = r_valid_all;

endmodule
`default_nettype wire

// File: tb/tb_argmax_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_collector
// Purpose  : Scoreboard bench for argmax_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_collector;

    localparam int NUM    = 10;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    typedef struct {
        int idx;
        int score;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   stim [NUM];
    exp_t sb_q [$];

    argmax_collector_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    argmax_collector #(
        .NUM_CLASSES (NUM),
        .DATA_W      (DATA_W),
        .IDX_W       (IDX_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected();
        exp_t e;
        e.idx   = 0;
        e.score = stim[0];
        for (int i = 1; i < NUM; i++) begin
            if (stim[i] > e.score) begin
                e.score = stim[i];
                e.idx   = i;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy", int'(bus.busy), 1);
        check("start_valid_clr", int'(bus.valid_all), 0);
    endtask

    task automatic send_stream(input int n, input bit gaps, input bit mid_start, input bit push);
        if (push) push_expected();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.in_valid = 1'b0;
                    bus.in_data  = DATA_W'(16'h7fff);
                    check("gap_ready", int'(bus.in_ready), 1);
                    tick();
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(stim[i]);
            if (mid_start && i == 4) bus.start = 1'b1;
            check("ready", int'(bus.in_ready), 1);
            check("valid_low", int'(bus.valid_all), 0);
            tick();
            bus.start = 1'b0;
        end
        bus.in_valid = 1'b0;
    endtask

    // Result monitor: pops the scoreboard whenever valid_all rises.
    int acc_cnt;
    bit prev_valid;
    always @(posedge clk) begin
        bit acc_edge;
        bit rst_edge;
        exp_t e;
        acc_edge = bus.in_valid && bus.in_ready;
        rst_edge = !rst_n;
        #1;
        if (rst_edge) acc_cnt = 0;
        else if (acc_edge) acc_cnt++;
        if (bus.valid_all && !prev_valid) begin
            check("done_on_accept", int'(acc_edge), 1);
            check("accept_count", acc_cnt, NUM);
            check("sb_pending", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("class_idx", int'(bus.class_idx), e.idx);
                check("max_score", int'(bus.max_score), e.score);
            end
            acc_cnt = 0;
        end
        prev_valid = bus.valid_all;
    end

    initial begin
        checks       = 0;
        errors       = 0;
        acc_cnt      = 0;
        prev_valid   = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = '0;
        repeat (3) tick();
        check("rst_class_idx", int'(bus.class_idx), 0);
        check("rst_max_score", int'(bus.max_score), 0);
        check("rst_valid", int'(bus.valid_all), 0);
        check("rst_ready", int'(bus.in_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (3) begin
            tick();
            check("idle_no_ready", int'(bus.in_ready), 0);
            check("idle_no_busy", int'(bus.busy), 0);
        end
        bus.in_valid = 1'b0;

        // Basic stream, back-to-back
        stim = '{3, -7, 12, 5, 0, 12, -1, 8, 2, 9};
        do_start();
        send_stream(NUM, 1'b0, 1'b0, 1'b1);
        check("done_busy", int'(bus.busy), 0);
        check("done_ready", int'(bus.in_ready), 0);

        // Hold in DONE with traffic on in_valid that must be ignored
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(16'h7fff - c);
            tick();
            check("hold_idx", int'(bus.class_idx), 2);
            check("hold_score", int'(bus.max_score), 12);
            check("hold_valid", int'(bus.valid_all), 1);
        end
        bus.in_valid = 1'b0;

        // All scores at the most negative value
        for (int i = 0; i < NUM; i++) stim[i] = -32768;
        do_start();
        send_stream(NUM, 1'b0, 1'b0, 1'b1);

        // Max in the last slot, stalled input
        for (int i = 0; i < NUM; i++) stim[i] = 1;
        stim[NUM-1] = 100;
        do_start();
        send_stream(NUM, 1'b1, 1'b0, 1'b1);

        // Start pulsed mid-collection must not restart
        stim = '{3, -7, 12, 5, 0, 12, -1, 8, 2, 9};
        do_start();
        send_stream(NUM, 1'b0, 1'b1, 1'b1);

        // Reset mid-collection discards the partial result
        stim = '{50, 60, 70, 80, 90, 1, 1, 1, 1, 1};
        do_start();
        send_stream(5, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_idx", int'(bus.class_idx), 0);
        check("midrst_score", int'(bus.max_score), 0);
        check("midrst_valid", int'(bus.valid_all), 0);
        check("midrst_busy", int'(bus.busy), 0);
        bus.in_valid = 1'b1;
        tick();
        check("midrst_idle_ready", int'(bus.in_ready), 0);
        bus.in_valid = 1'b0;
        stim = '{-5, 4, -3, 4, 2, -9, 0, 1, 3, -2};
        do_start();
        send_stream(NUM, 1'b1, 1'b0, 1'b1);

        // Random streams with frequent ties
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM; i++) stim[i] = int'($urandom_range(0, 20)) - 10;
            do_start();
            send_stream(NUM, r[0], 1'b0, 1'b1);
        end

        for (int t = 0; t < 200 && sb_q.size() > 0; t++) tick();
        check("sb_drained", sb_q.size(), 0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
